// File: rtl/gh_key_pio_irq.sv
// gh_key_pio_irq: Avalon-MM input PIO for the GuitarHero key/fret inputs.
// Each channel is synchronised and optionally debounced. Edges of the
// selected polarity are captured in sticky bits, and a masked level
// interrupt is raised from them.
// Optional feature macro: GH_KEY_DEBOUNCE_EN enables the per-channel
// debounce counters. When it is undefined, stable follows s2 with a
// one-cycle delay.
// Register map (word address):
//   0 data (read-only), 1 reserved (reads 0), 2 irqmask (R/W),
//   3 edgecapture (write 1 to clear).
module gh_key_pio_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchroniser for the raw asynchronous key inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef GH_KEY_DEBOUNCE_EN
  // The counter holds (number of consecutive differing cycles - 1) at the
  // edge where the change is accepted, so DEBOUNCE_CYCLES=1 degenerates
  // to the undebounced timing.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt;

  // Accept a channel's new level on its final consecutive differing cycle
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      if ((s2[i] != stable[i]) && (cnt[i] == CNT_LAST)) begin
        stable_nxt[i] = s2[i];
      end
    end
  end

  // Per-channel run length of cycles where s2 disagrees with stable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((s2[i] == stable[i]) || (cnt[i] == CNT_LAST)) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign unused_ok = ^writedata;
`else
  assign stable_nxt = s2;
  assign unused_ok  = ^{writedata, 32'(DEBOUNCE_CYCLES), 32'(CNT_W)};
`endif

  // Edge polarity is fixed at elaboration
  if (EDGE_MODE == 0) begin : g_rise
    assign edge_set = stable_nxt & ~stable;
  end else if (EDGE_MODE == 1) begin : g_fall
    assign edge_set = ~stable_nxt & stable;
  end else begin : g_both
    assign edge_set = stable_nxt ^ stable;
  end

  assign edge_clr = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  // Debounced level, sticky edge capture (a new edge beats a clear), and mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable  <= '0;
      edgecap <= '0;
      irqmask <= '0;
    end else begin
      stable  <= stable_nxt;
      edgecap <= (edgecap & ~edge_clr) | edge_set;
      if (wr_en && (address == 2'd2)) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Register read mux, zero-extending every field to the bus width
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(stable);
      2'd1:    rd_mux = '0;
      2'd2:    rd_mux = 32'(irqmask);
      default: rd_mux = 32'(edgecap);
    endcase
  end

  // Read data is loaded every cycle, independent of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: doc/gh_key_pio_irq.md
# gh_key_pio_irq

Parametrised Avalon-MM input PIO for the GuitarHero key and fret inputs. It replaces the fixed 2-bit, data-only key port with the following features:
- N channels, each with a synchroniser and an optional per-channel debouncer.
- Per-bit edge capture with configurable polarity.
- An interrupt mask and a level interrupt to the Nios II.

It sits between the board pushbuttons/switches and the system interconnect.

## Interface
Parameters:
- WIDTH, 4: number of input channels, legal 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a change, legal ≥1 (1 ms at 50 MHz).
- CNT_W, 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- EDGE_MODE, 0: 0 = capture rising edges, 1 = falling, 2 = both.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous key inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Synchroniser: in_port passes through two flops (s1, s2) per bit. Reset value 0.
- Debounce (per bit, when compiled in):
  - Counter cnt[i] increments each cycle s2[i] != stable[i].
  - cnt[i] clears to 0 on any cycle s2[i] == stable[i].
  - When the count of consecutive differing cycles reaches DEBOUNCE_CYCLES, stable[i] <= s2[i] and cnt[i] <= 0 on that edge.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge capture:
  - edgecap[i] sets on the same edge that stable[i] changes in the selected direction.
  - Once set, edgecap[i] stays set until it is cleared by software.
- Register map (word addresses):
  - 0 data: read-only; stable zero-extended to 32 bits; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 irqmask: R/W, bits WIDTH-1:0; upper bits read 0.
  - 3 edgecapture: read returns edgecap. A write clears every bit i where writedata[i] = 1 (write-1-to-clear).
- Writes take effect on the clk edge where chipselect = 1 and write_n = 0.
- readdata is loaded every cycle from the mux selected by address, independent of chipselect.
- irq = |(edgecap & irqmask), combinational from flops only (glitch-free).
- Simultaneous new edge and W1C on the same bit: the set wins, and the bit remains 1.
- Simultaneous irqmask write and edge: irq reflects the new mask from the next cycle.

## Timing
- Reset (asynchronous, any time, including mid-debounce):
  - s1, s2, stable, cnt, edgecap, irqmask, readdata all go to 0, and irq goes to 0.
  - After reset, inputs that are held at 1 are treated as a rising edge once debounced.
- Read latency: 1 cycle. address presented before edge E yields readdata valid after E.
- Input change set up before edge E0:
  - s2 reflects it after E1.
  - With debounce, stable and edgecap update at E1+DEBOUNCE_CYCLES, readable at address 0 or 3 one cycle later.
  - irq asserts after E1+DEBOUNCE_CYCLES.
- Without debounce: stable <= s2 every cycle, so stable and edgecap update at E2.
- irq deasserts on the edge that clears the last masked edgecap bit or the mask bit.

## Configuration
- GH_KEY_DEBOUNCE_EN:
  - When defined: per-channel counters exist and DEBOUNCE_CYCLES and CNT_W are used.
  - When undefined: no counters are instantiated, DEBOUNCE_CYCLES and CNT_W are ignored, and stable is a one-cycle register of s2 (3-cycle input-to-stable latency).
  - The register map and irq behaviour are identical in both builds.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=8, EDGE_MODE=0, and the macro defined unless stated otherwise.

- Reset: assert reset_n=0 mid-count with in_port=4'hF. Required: readdata=0 and irq=0 immediately. After release, data reads 4'hF only after 2+8 cycles.
- Glitch reject: pulse in_port[1] high for 7 cycles. Required: data stays 0, edgecap stays 0. A 9-cycle pulse gives data=4'h2 at E1+8, then 0 again after fall plus 8.
- IRQ flow: write irqmask=4'h2, then raise in_port[1]. Required:
  - irq=1 and edgecapture reads 4'h2.
  - Writing 4'h1 to address 3 leaves irq=1.
  - Writing 4'h2 to address 3 gives irq=0 the next cycle.
- Mask gating: with edgecap=4'h5 and irqmask=0, irq=0. Writing irqmask=4'h4 gives irq=1 after that edge.
- Set/clear collision: W1C of bit 0 on the exact edge stable[0] rises. Required: edgecap[0]=1 afterwards.
- Macro undefined, EDGE_MODE=2: toggling in_port[3] gives data bit 3 after 3 edges. edgecap[3] sets on both rise and fall. Reading address 1 returns 0.
